// File: rtl/scan_register.sv
// rtl/scan_register.sv - mux-D scan register with serial scan path
//
// Purpose:
//   Parallel-capture storage element with a serial shift path for
//   STUMPS-style BIST scan chains. TC=0 captures D, TC=1 shifts SD into
//   bit 0. Q is the register itself and Q[WIDTH-1] is the scan-out.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset (0 = reset), loads RST_VAL
//   TC   - test control: 1 = shift, 0 = capture
//   SD   - serial scan data in (enters bit 0)
//   D    - parallel functional data in [WIDTH-1:0]
//   Q    - register contents [WIDTH-1:0], Q[WIDTH-1] is scan-out
//
// Parameters:
//   WIDTH   - number of flops, 1..64
//   RST_VAL - reset value of the register
//
// Build option:
//   SCAN_REG_MISR_CAPTURE_EN - when defined, capture compacts
//   D ^ rotate_left(R) instead of loading D. Shift and reset unchanged.

module scan_register #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             TC,
    input  logic             SD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] capture_val;
    logic [WIDTH-1:0] next_r;
    logic             armed;

    // Release qualifier: sampled on the falling edge, so a rising edge that
    // coincides with (or closely follows) reset release always sees armed=0
    // and leaves R at RST_VAL. Updates resume from the next rising edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    generate
        if (WIDTH == 1) begin : g_w1
            assign shift_val = SD;
`ifdef SCAN_REG_MISR_CAPTURE_EN
            assign capture_val = D ^ r;
`else
            assign capture_val = D;
`endif
        end else begin : g_wn
            assign shift_val = {r[WIDTH-2:0], SD};
`ifdef SCAN_REG_MISR_CAPTURE_EN
            // Rotate-left then XOR with D: simple signature compaction.
            assign capture_val = D ^ {r[WIDTH-2:0], r[WIDTH-1]};
`else
            assign capture_val = D;
`endif
        end
    endgenerate

    always_comb begin
        next_r = r;
        if (armed) begin
            next_r = TC ? shift_val : capture_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r <= RST_VAL;
        end else begin
            r <= next_r;
        end
    end

    assign Q = r;

endmodule

// File: tb/tb_scan_register.sv
// tb/tb_scan_register.sv - directed self-checking bench for scan_register

module tb_scan_register;

    logic       clk;
    logic       rst1, tc1, sd1;
    logic [0:0] d1, q1;
    logic       rst4, tc4, sd4;
    logic [3:0] d4, q4;

    int n_cmp = 0;
    int n_err = 0;

    scan_register #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst1), .TC(tc1), .SD(sd1), .D(d1), .Q(q1)
    );

    scan_register #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst4), .TC(tc4), .SD(sd4), .D(d4), .Q(q4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b0; rst4 = 1'b0;
        tc1 = 1'b0; sd1 = 1'b0; d1 = 1'b1;
        tc4 = 1'b0; sd4 = 1'b0; d4 = 4'hF;
        #1;
        n_cmp++;
        if (q1 !== 1'b0) begin n_err++; $display("FAIL reset_w1 got %b want 0", q1); end
        n_cmp++;
        if (q4 !== 4'b0000) begin n_err++; $display("FAIL reset_w4 got %b want 0000", q4); end
        tick();
        n_cmp++;
        if (q4 !== 4'b0000) begin n_err++; $display("FAIL reset_hold_w4 got %b want 0000", q4); end
        rst1 = 1'b1; rst4 = 1'b1;
    endtask

    task automatic test_capture_w1();
        logic exp_b;
        tc1 = 1'b0; d1 = 1'b1; sd1 = 1'b0;
        tick();
        n_cmp++;
        if (q1 !== 1'b1) begin n_err++; $display("FAIL capture_w1_a got %b want 1", q1); end
        d1 = 1'b0; sd1 = 1'b1;
`ifdef SCAN_REG_MISR_CAPTURE_EN
        exp_b = 1'b1;
`else
        exp_b = 1'b0;
`endif
        tick();
        n_cmp++;
        if (q1 !== exp_b) begin n_err++; $display("FAIL capture_w1_b got %b want %b", q1, exp_b); end
    endtask

    task automatic test_shift_w1();
        tc1 = 1'b1; sd1 = 1'b1; d1 = 1'b0;
        tick();
        n_cmp++;
        if (q1 !== 1'b1) begin n_err++; $display("FAIL shift_w1_a got %b want 1", q1); end
        sd1 = 1'b0; d1 = 1'b1;
        tick();
        n_cmp++;
        if (q1 !== 1'b0) begin n_err++; $display("FAIL shift_w1_b got %b want 0", q1); end
        sd1 = 1'b1;
        tick();
        n_cmp++;
        if (q1 !== 1'b1) begin n_err++; $display("FAIL shift_w1_c got %b want 1", q1); end
    endtask

    task automatic test_async_reset_w1();
        tc1 = 1'b0; d1 = 1'b1;
        #3;
        rst1 = 1'b0;
        #1;
        n_cmp++;
        if (q1 !== 1'b0) begin n_err++; $display("FAIL async_reset_w1 got %b want 0", q1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (q1 !== 1'b0) begin n_err++; $display("FAIL async_hold_w1[%0d] got %b want 0", i, q1); end
        end
        rst1 = 1'b1;
    endtask

    task automatic test_shift_load_w4();
        logic [3:0] sd_seq;
        logic [3:0] exp_q [4];
        logic [3:0] exp_cap;
        logic [3:0] exp_out;
        sd_seq = 4'b1101;   // bit i applied on shift i: 1,0,1,1
        exp_q[0] = 4'b0001; exp_q[1] = 4'b0010; exp_q[2] = 4'b0101; exp_q[3] = 4'b1011;
        rst4 = 1'b0;
        #1;
        tick();
        rst4 = 1'b1;
        tc4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sd4 = sd_seq[i];
            tick();
            n_cmp++;
            if (q4 !== exp_q[i]) begin n_err++; $display("FAIL shift_load_w4[%0d] got %b want %b", i, q4, exp_q[i]); end
        end
`ifdef SCAN_REG_MISR_CAPTURE_EN
        exp_cap = 4'b0001;  // rotl(1011)=0111 ^ 0110
        exp_out = 4'b1000;  // Q[3] sequence 0,0,0,1 (index = shift number)
`else
        exp_cap = 4'b0110;
        exp_out = 4'b0110;  // Q[3] sequence 0,1,1,0
`endif
        tc4 = 1'b0; d4 = 4'b0110;
        tick();
        n_cmp++;
        if (q4 !== exp_cap) begin n_err++; $display("FAIL capture_w4 got %b want %b", q4, exp_cap); end
        tc4 = 1'b1; sd4 = 1'b0; d4 = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (q4[3] !== exp_out[i]) begin n_err++; $display("FAIL scan_out_w4[%0d] got %b want %b", i, q4[3], exp_out[i]); end
            tick();
        end
        n_cmp++;
        if (q4 !== 4'b0000) begin n_err++; $display("FAIL unload_w4 got %b want 0000", q4); end
    endtask

    task automatic test_mode_switch_w4();
        tc4 = 1'b0; d4 = 4'b1010;
        tick();
        n_cmp++;
        if (q4 !== 4'b1010) begin n_err++; $display("FAIL mode_cap_w4 got %b want 1010", q4); end
        tc4 = 1'b1; sd4 = 1'b1; d4 = 4'b0101;
        #2; tc4 = 1'b0;
        #2; tc4 = 1'b1;
        #2;
        n_cmp++;
        if (q4 !== 4'b1010) begin n_err++; $display("FAIL mode_between_edges_w4 got %b want 1010", q4); end
        tick();
        n_cmp++;
        if (q4 !== 4'b0101) begin n_err++; $display("FAIL mode_edge_tc_w4 got %b want 0101", q4); end
    endtask

    task automatic test_reset_interplay_w4();
        tc4 = 1'b1; sd4 = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (q4 !== 4'b0111) begin n_err++; $display("FAIL midshift_w4 got %b want 0111", q4); end
        #3;
        rst4 = 1'b0;
        #1;
        n_cmp++;
        if (q4 !== 4'b0000) begin n_err++; $display("FAIL midshift_reset_w4 got %b want 0000", q4); end
        tick();
        n_cmp++;
        if (q4 !== 4'b0000) begin n_err++; $display("FAIL reset_held_w4 got %b want 0000", q4); end
        tc4 = 1'b0; d4 = 4'b1111;
        @(posedge clk);
        rst4 = 1'b1;
        #1;
        n_cmp++;
        if (q4 !== 4'b0000) begin n_err++; $display("FAIL release_edge_w4 got %b want 0000", q4); end
        tick();
        n_cmp++;
        if (q4 !== 4'b1111) begin n_err++; $display("FAIL resume_w4 got %b want 1111", q4); end
    endtask

    task automatic test_back_to_back_capture_w4();
        logic [3:0] exp_second;
`ifdef SCAN_REG_MISR_CAPTURE_EN
        exp_second = 4'b0011;   // rotl(0001)=0010 ^ 0001
`else
        exp_second = 4'b0001;
`endif
        rst4 = 1'b0;
        #1;
        tick();
        rst4 = 1'b1;
        tc4 = 1'b0; d4 = 4'b0001;
        tick();
        n_cmp++;
        if (q4 !== 4'b0001) begin n_err++; $display("FAIL b2b_first_w4 got %b want 0001", q4); end
        tick();
        n_cmp++;
        if (q4 !== exp_second) begin n_err++; $display("FAIL b2b_second_w4 got %b want %b", q4, exp_second); end
    endtask

    initial begin
        test_reset();
        test_capture_w1();
        test_shift_w1();
        test_async_reset_w1();
        test_shift_load_w4();
        test_mode_switch_w4();
        test_reset_interplay_w4();
        test_back_to_back_capture_w4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
